fadd_norm_round: RTL and testbench
==================================

// Module: fadd_norm_round
// PURPOSE
//  Final stage of the pipelined FP adder; sits after the cal->norm pipeline register.
//  Consumes the registered 28-bit unnormalized sum and normalizes it by 1-bit right shift or LZC left shift.
//  Rounds it per rm and packs the IEEE-754 single result.
//  Two internal pipeline sub-stages (A: normalize, B: round/pack) with valid tracking and stall.
// PARAMETERS
//  none; 32-bit single precision is fixed.
// PORTS
//  clk             in   1   clock, all flops rising edge
//  clrn            in   1   asynchronous active-low reset
//  e               in   1   pipeline enable; 0 freezes both sub-stages
//  n_valid         in   1   input operand valid
//  n_frac          in   28  [27]=carry, [26]=hidden, [25:3]=fraction, [2:0]=guard/round/sticky
//  n_inf_nan_frac  in   23  NaN payload fraction
//  n_exp           in   8   biased exponent of n_frac (hidden bit at [26])
//  n_rm            in   2   00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
//  n_is_nan, n_is_inf, n_sign   in 1 each   special-case flags, result sign
//  s               out  32  packed result
//  s_valid         out  1   s is valid
//  s_ovf           out  1   exponent overflow occurred
//  s_inexact       out  1   any of g/r/s set before rounding
// BEHAVIOUR
//  - clrn=0: all stage-A/B registers and all outputs are 0 immediately; in-flight ops are discarded.
//  - Latency 2 enabled cycles: inputs sampled at edge k (e=1) appear on s at edge k+1 (e=1).
//  - e=0: no register updates; outputs hold. Valid bits advance only with e; bubbles (n_valid=0) propagate.
//  - Stage A, normalize (27-bit f, hidden at [26]):
//    - n_frac[27]=1: f = n_frac[27:1] with f[0] |= n_frac[0]; exp+1.
//    - n_frac=0: f=0, exp=0.
//    - else lz = leading zeros of n_frac[26:0]:
//      - exp>lz: shift left lz, exp-lz.
//      - exp>=1 and lz>=exp: shift left exp-1, exp=0 (denormal).
//      - exp=0: no shift.
//  - Stage B, round: lsb=f[3], g=f[2], r=f[1], st=f[0].
//    - inc: rm00 g&(r|st|lsb); rm01 sign&(g|r|st); rm10 ~sign&(g|r|st); rm11 0.
//    - {exp8,frac23} = {exp,f[25:3]} + inc (31-bit add; carry moves denormal->normal and frac->exp naturally).
//    - inexact = g|r|st.
//  - Overflow: exp reaches 255 after stage A or after rounding -> s_ovf=1.
//    - Result is inf {sign,8'hff,0} for rm00, rm10 with sign=0, rm01 with sign=1; otherwise max finite {sign,31'h7f7fffff}.
//  - Specials, priority NaN > inf > normal:
//    - NaN: s = {1'b0, 8'hff, n_inf_nan_frac | 23'h400000}.
//    - inf: s = {sign, 8'hff, 23'h0}.
//    - For both, ovf=0 and inexact=0.
//  - Zero result: s = {sign, 31'h0}.
//  - Special flags, rm, sign and payload pipe alongside through both sub-stages.
// STRUCTURE
//  Shared fpu package: FP_EXP_W=8, FP_FRAC_W=23, EXP_MAX=8'hff, QNAN_BIT=22, rm encodings RM_RNE/RM_RDN/RM_RUP/RM_RTZ.
//  One sub-module: fpu_lzc27 (combinational 27-bit leading-zero counter, 5-bit count, count=27 for zero).
//  Stage A register and output register live in this module.
// TESTING
//  - n_frac=28'h8000000, exp=127, rm=00, valid -> after 2 cycles s=32'h40000000, ovf=0, inexact=0.
//  - n_frac=28'h400000C, exp=127, rm=00 -> s=32'h3F800002, inexact=1; same with rm=11 -> s=32'h3F800001.
//  - n_frac=28'h8000000, exp=254: rm=00 -> s=32'h7F800000, ovf=1; rm=11 -> s=32'h7F7FFFFF, ovf=1.
//  - n_frac=28'h0000008, exp=127 -> s=32'h34000000; n_frac=28'h1000000, exp=1 -> s=32'h00200000.
//  - Back-to-back valids with e=0 for 3 cycles mid-stream -> outputs hold, no op lost or duplicated, order kept.
//  - clrn pulsed low while 2 ops in flight -> s=0, s_valid=0 at once; next op emerges 2 cycles after clrn=1.
//  - n_is_nan=1, payload 23'h000001 -> s=32'h7FC00001.

Source files
------------

// File: rtl/fadd_norm_round_pkg.sv
// Shared single-precision FP definitions for the adder back end:
// field widths, the all-ones exponent, the quiet-NaN bit position,
// rounding-mode encodings and the stage-A pipeline record.
package fadd_norm_round_pkg;

  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;
  localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hff;
  localparam int unsigned QNAN_BIT  = 22;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RDN = 2'b01,
    RM_RUP = 2'b10,
    RM_RTZ = 2'b11
  } rm_e;

  // Normalized operand held between the normalize and round/pack sub-stages.
  typedef struct packed {
    logic                 valid;
    logic                 is_nan;
    logic                 is_inf;
    logic                 sign;
    rm_e                  rm;
    logic [FP_FRAC_W-1:0] payload;
    logic                 ovf;
    logic [FP_EXP_W-1:0]  exp;
    logic [26:0]          f;
  } stage_a_t;

endpackage

// File: rtl/fadd_norm_round_lzc.sv
// fpu_lzc27: combinational leading-zero counter for a 27-bit vector.
//   x     in  27  value to scan from bit 26 downward
//   count out 5   number of leading zeros, 27 when x is zero
module fpu_lzc27
  import fadd_norm_round_pkg::*;
(
  input  logic [26:0] x,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is seen last and wins.
  always_comb begin
    count = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (x[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fadd_norm_round.sv
// fadd_norm_round: final stage of the pipelined FP adder.
// Normalizes the registered 28-bit unnormalized sum (stage A), then
// rounds and packs the IEEE-754 single result (stage B / output register).
//   clk, clrn                  clock, async active-low reset
//   e                          pipeline enable, 0 freezes both sub-stages
//   n_valid, n_frac, n_exp     operand valid, unnormalized sum, its exponent
//   n_inf_nan_frac             NaN payload
//   n_rm, n_is_nan, n_is_inf,
//   n_sign                     rounding mode, special flags, result sign
//   s, s_valid, s_ovf,
//   s_inexact                  packed result and status
module fadd_norm_round
  import fadd_norm_round_pkg::*;
(
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 e,
  input  logic                 n_valid,
  input  logic [27:0]          n_frac,
  input  logic [FP_FRAC_W-1:0] n_inf_nan_frac,
  input  logic [FP_EXP_W-1:0]  n_exp,
  input  logic [1:0]           n_rm,
  input  logic                 n_is_nan,
  input  logic                 n_is_inf,
  input  logic                 n_sign,
  output logic [31:0]          s,
  output logic                 s_valid,
  output logic                 s_ovf,
  output logic                 s_inexact
);

  stage_a_t a_d, a_q;
  logic [4:0] lz;
  logic [8:0] exp_inc;

  fpu_lzc27 u_lzc (
    .x     (n_frac[26:0]),
    .count (lz)
  );

  // Stage A: normalize
  always_comb begin
    a_d         = '0;
    a_d.valid   = n_valid;
    a_d.is_nan  = n_is_nan;
    a_d.is_inf  = n_is_inf;
    a_d.sign    = n_sign;
    a_d.rm      = rm_e'(n_rm);
    a_d.payload = n_inf_nan_frac;
    exp_inc     = {1'b0, n_exp} + 9'd1;
    if (n_frac[27]) begin
      // Carry out: shift right one, folding the dropped bit into sticky.
      a_d.f   = {n_frac[27:2], n_frac[1] | n_frac[0]};
      a_d.exp = exp_inc[7:0];
      a_d.ovf = (exp_inc >= 9'(EXP_MAX));
    end else if (n_frac == '0) begin
      a_d.f   = '0;
      a_d.exp = '0;
    end else if (n_exp > {3'b0, lz}) begin
      a_d.f   = n_frac[26:0] << lz;
      a_d.exp = n_exp - {3'b0, lz};
    end else if (n_exp != '0) begin
      // Not enough exponent range to fully normalize: result is denormal.
      a_d.f   = n_frac[26:0] << (n_exp - 8'd1);
      a_d.exp = '0;
    end else begin
      a_d.f   = n_frac[26:0];
      a_d.exp = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)  a_q <= '0;
    else if (e) a_q <= a_d;
  end

  // Stage B: round and pack
  logic        g, r, st, lsb, inc, inexact, ovf, to_inf;
  logic [30:0] sum;
  logic [31:0] s_d;
  logic        ovf_d, inexact_d;

  always_comb begin
    lsb     = a_q.f[3];
    g       = a_q.f[2];
    r       = a_q.f[1];
    st      = a_q.f[0];
    inexact = g | r | st;
    unique case (a_q.rm)
      RM_RNE:  inc = g & (r | st | lsb);
      RM_RDN:  inc = a_q.sign & inexact;
      RM_RUP:  inc = ~a_q.sign & inexact;
      default: inc = 1'b0;
    endcase
    // Mantissa carry ripples into the exponent field by construction.
    sum    = {a_q.exp, a_q.f[25:3]} + 31'(inc);
    ovf    = a_q.ovf | (sum[30:23] == EXP_MAX);
    to_inf = (a_q.rm == RM_RNE) || (a_q.rm == RM_RUP && !a_q.sign) ||
             (a_q.rm == RM_RDN && a_q.sign);

    s_d       = {a_q.sign, sum};
    ovf_d     = 1'b0;
    inexact_d = inexact;
    if (a_q.is_nan) begin
      s_d       = {1'b0, EXP_MAX, a_q.payload | (23'(1) << QNAN_BIT)};
      inexact_d = 1'b0;
    end else if (a_q.is_inf) begin
      s_d       = {a_q.sign, EXP_MAX, 23'h0};
      inexact_d = 1'b0;
    end else if (ovf) begin
      ovf_d = 1'b1;
      s_d   = to_inf ? {a_q.sign, EXP_MAX, 23'h0} : {a_q.sign, 31'h7f7fffff};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s         <= '0;
      s_valid   <= 1'b0;
      s_ovf     <= 1'b0;
      s_inexact <= 1'b0;
    end else if (e) begin
      s         <= s_d;
      s_valid   <= a_q.valid;
      s_ovf     <= ovf_d;
      s_inexact <= inexact_d;
    end
  end

endmodule

// File: tb/tb_fadd_norm_round.sv
module tb_fadd_norm_round;

  logic        clk, clrn, e, n_valid;
  logic [27:0] n_frac;
  logic [22:0] n_inf_nan_frac;
  logic [7:0]  n_exp;
  logic [1:0]  n_rm;
  logic        n_is_nan, n_is_inf, n_sign;
  logic [31:0] s;
  logic        s_valid, s_ovf, s_inexact;

  int checks = 0;
  int failures = 0;

  fadd_norm_round dut (
    .clk(clk), .clrn(clrn), .e(e), .n_valid(n_valid), .n_frac(n_frac),
    .n_inf_nan_frac(n_inf_nan_frac), .n_exp(n_exp), .n_rm(n_rm),
    .n_is_nan(n_is_nan), .n_is_inf(n_is_inf), .n_sign(n_sign),
    .s(s), .s_valid(s_valid), .s_ovf(s_ovf), .s_inexact(s_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input [27:0] fr, input [7:0] ex, input [1:0] rm, input sg,
                       input nan, input inf, input [22:0] pl);
    n_valid = 1'b1; n_frac = fr; n_exp = ex; n_rm = rm; n_sign = sg;
    n_is_nan = nan; n_is_inf = inf; n_inf_nan_frac = pl;
  endtask

  // Issue one op and return {s, ovf, inexact, valid} two edges later.
  task automatic run_op(input [27:0] fr, input [7:0] ex, input [1:0] rm, input sg,
                        input nan, input inf, input [22:0] pl, output [34:0] res);
    @(negedge clk);
    drive(fr, ex, rm, sg, nan, inf, pl);
    @(posedge clk); #1;
    n_valid = 1'b0;
    @(posedge clk); #1;
    res = {s, s_ovf, s_inexact, s_valid};
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({s, s_ovf, s_inexact, s_valid} !== 35'h0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", {s, s_ovf, s_inexact, s_valid});
    end
    @(negedge clk); clrn = 1'b1;
  endtask

  task automatic test_basic;
    logic [34:0] got;
    logic [34:0] want [5];
    logic [27:0] fr [5];
    logic [7:0]  ex [5];
    logic [1:0]  rm [5];
    logic        sg [5];
    fr = '{28'h8000000, 28'h400000C, 28'h400000C, 28'h400000C, 28'h400000C};
    ex = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
    rm = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b01};
    sg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    want = '{{32'h40000000, 3'b001}, {32'h3F800002, 3'b011}, {32'h3F800001, 3'b011},
             {32'h3F800002, 3'b011}, {32'h3F800001, 3'b011}};
    for (int i = 0; i < 5; i++) begin
      run_op(fr[i], ex[i], rm[i], sg[i], 1'b0, 1'b0, 23'h0, got);
      checks++;
      if (got !== want[i]) begin
        failures++;
        $display("FAIL round_%0d got=%h want=%h", i, got, want[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [34:0] got;
    logic [34:0] want [5];
    logic [27:0] fr [5];
    logic [1:0]  rm [5];
    logic        sg [5];
    fr = '{28'h8000000, 28'h8000000, 28'h8000000, 28'h8000000, 28'h7FFFFFF};
    rm = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    sg = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    want = '{{32'h7F800000, 3'b101}, {32'h7F7FFFFF, 3'b101}, {32'hFF800000, 3'b101},
             {32'hFF7FFFFF, 3'b101}, {32'h7F800000, 3'b111}};
    for (int i = 0; i < 5; i++) begin
      run_op(fr[i], 8'd254, rm[i], sg[i], 1'b0, 1'b0, 23'h0, got);
      checks++;
      if (got !== want[i]) begin
        failures++;
        $display("FAIL overflow_%0d got=%h want=%h", i, got, want[i]);
      end
    end
  endtask

  task automatic test_normalize;
    logic [34:0] got;
    run_op(28'h0000008, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0, got);
    checks++;
    if (got !== {32'h34000000, 3'b001}) begin
      failures++; $display("FAIL lzc_shift got=%h want=%h", got, {32'h34000000, 3'b001});
    end
    run_op(28'h1000000, 8'd1, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0, got);
    checks++;
    if (got !== {32'h00200000, 3'b001}) begin
      failures++; $display("FAIL denormal got=%h want=%h", got, {32'h00200000, 3'b001});
    end
    run_op(28'h0, 8'd90, 2'b00, 1'b1, 1'b0, 1'b0, 23'h0, got);
    checks++;
    if (got !== {32'h80000000, 3'b001}) begin
      failures++; $display("FAIL zero got=%h want=%h", got, {32'h80000000, 3'b001});
    end
  endtask

  task automatic test_specials;
    logic [34:0] got;
    run_op(28'h0000007, 8'd5, 2'b00, 1'b1, 1'b1, 1'b1, 23'h000001, got);
    checks++;
    if (got !== {32'h7FC00001, 3'b001}) begin
      failures++; $display("FAIL nan got=%h want=%h", got, {32'h7FC00001, 3'b001});
    end
    run_op(28'h8000007, 8'd254, 2'b00, 1'b1, 1'b0, 1'b1, 23'h0, got);
    checks++;
    if (got !== {32'hFF800000, 3'b001}) begin
      failures++; $display("FAIL inf got=%h want=%h", got, {32'hFF800000, 3'b001});
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(28'h8000000, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0);
    @(negedge clk);
    drive(28'h400000C, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0);
    @(posedge clk); #1;
    checks++;
    if ({s, s_valid} !== {32'h40000000, 1'b1}) begin
      failures++; $display("FAIL b2b_first got=%h want=%h", {s, s_valid}, {32'h40000000, 1'b1});
    end
    @(negedge clk);
    drive(28'h0000008, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0);
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({s, s_valid} !== {32'h40000000, 1'b1}) begin
        failures++; $display("FAIL stall_hold_%0d got=%h want=%h", i, {s, s_valid}, {32'h40000000, 1'b1});
      end
    end
    @(negedge clk); e = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s, s_valid} !== {32'h3F800002, 1'b1}) begin
      failures++; $display("FAIL b2b_second got=%h want=%h", {s, s_valid}, {32'h3F800002, 1'b1});
    end
    @(negedge clk); n_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s, s_valid} !== {32'h34000000, 1'b1}) begin
      failures++; $display("FAIL b2b_third got=%h want=%h", {s, s_valid}, {32'h34000000, 1'b1});
    end
    @(posedge clk); #1;
    checks++;
    if (s_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_bubble got=%b want=0", s_valid);
    end
  endtask

  task automatic test_clrn_midflight;
    @(negedge clk);
    drive(28'h8000000, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0);
    @(negedge clk);
    drive(28'h400000C, 8'd127, 2'b11, 1'b0, 1'b0, 1'b0, 23'h0);
    @(negedge clk);
    n_valid = 1'b0;
    clrn = 1'b0;
    #1;
    checks++;
    if ({s, s_valid} !== 33'h0) begin
      failures++; $display("FAIL clrn_async got=%h want=0", {s, s_valid});
    end
    @(negedge clk);
    clrn = 1'b1;
    drive(28'h0000008, 8'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0);
    @(posedge clk); #1;
    n_valid = 1'b0;
    checks++;
    if (s_valid !== 1'b0) begin
      failures++; $display("FAIL clrn_discard got=%b want=0", s_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({s, s_valid} !== {32'h34000000, 1'b1}) begin
      failures++; $display("FAIL clrn_next_op got=%h want=%h", {s, s_valid}, {32'h34000000, 1'b1});
    end
  endtask

  initial begin
    clrn = 1'b0; e = 1'b1; n_valid = 1'b0; n_frac = '0; n_exp = '0; n_rm = '0;
    n_sign = 1'b0; n_is_nan = 1'b0; n_is_inf = 1'b0; n_inf_nan_frac = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_normalize();
    test_specials();
    test_back_to_back();
    test_clrn_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
